uart_tx_sched: RTL and testbench

Transmit scheduler between the SOC memory bus and the `corescore_emitter_uart` byte emitter.
- Buffers bytes written by firmware in a DEPTH-entry FIFO and feeds them to the emitter under a valid/ready handshake.
- Exposes a status/control register so firmware polls only when the FIFO is full, not once per byte.
- Sits in the UART window at 0x4000_0000 and keeps the existing DAT (+0x8) / CTL (+0x10) offsets and the CTL busy bit 9.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/uart_tx_sched.sv | 127 ++++++++++++
 tb/tb_uart_tx_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//   - Register offsets within the UART window (DAT, CTL).
//   - CTL register bit positions for status read-back and control writes.
//   - Output FSM state encoding.
package uart_pkg;

  localparam logic [4:0] DAT_OFF = 5'h08;
  localparam logic [4:0] CTL_OFF = 5'h10;

  // CTL read-back status bits
  localparam int CTL_FULL   = 9;
  localparam int CTL_IDLE   = 10;
  localparam int CTL_OVF    = 11;
  // CTL write control bits
  localparam int CTL_FLUSH  = 0;
  localparam int CTL_OVFCLR = 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: DEPTH x 8-bit synchronous FIFO with flush.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   push, push_data   write request and byte; ignored when full or flushing
//   pop               read request; ignored when empty
//   flush             clears count and pointers (wins over push)
//   pop_data          current head byte (combinational)
//   count             occupancy 0..DEPTH
//   full, empty       occupancy flags, reflecting the start of the cycle
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [7:0]       pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = CNT_W - 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & ~full & ~flush;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: buffers firmware-written bytes and feeds them to the UART
// byte emitter under a valid/ready handshake.
// Ports:
//   i_clk, i_rst             clock, asynchronous active-high reset
//   bus_valid/we/addr/wdata  bus access, pre-qualified by window decode
//   bus_rdata                registered read data (1-cycle latency)
//   o_data, o_valid, i_ready byte handshake towards the emitter
//   o_irq_empty              level: FIFO empty and no byte in flight
// Registers: DAT (+0x08) pushes wdata[7:0]; CTL (+0x10) reads
//   {ovf, idle, full, count}, write bit0 flushes, bit1 clears OVF.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [4:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_irq_empty
);

  tx_state_e        state, state_next;
  logic             dat_wr, ctl_wr, rd_en;
  logic             flush, ovf_clr, push_ok, push_drop;
  logic             pop, load;
  logic             ovf;
  logic [7:0]       head;
  logic [CNT_W-1:0] count;
  logic             full, empty, idle;
  logic             unused_wdata;

  function automatic logic [31:0] ctl_word(input logic [CNT_W-1:0] cnt,
                                           input logic f, input logic idl,
                                           input logic ov);
    logic [31:0] w;
    w              = '0;
    w[CNT_W-1:0]   = cnt;
    w[CTL_FULL]    = f;
    w[CTL_IDLE]    = idl;
    w[CTL_OVF]     = ov;
    return w;
  endfunction

  assign dat_wr    = bus_valid & bus_we & (bus_addr == DAT_OFF);
  assign ctl_wr    = bus_valid & bus_we & (bus_addr == CTL_OFF);
  assign rd_en     = bus_valid & ~bus_we;
  assign flush     = ctl_wr & bus_wdata[CTL_FLUSH];
  assign ovf_clr   = ctl_wr & bus_wdata[CTL_OVFCLR];
  // Fullness is judged at the start of the cycle, so a same-cycle pop
  // does not rescue a push into a full FIFO.
  assign push_ok   = dat_wr & ~full & ~flush;
  assign push_drop = dat_wr & full & ~flush;
  assign idle      = empty & (state == S_IDLE);
  assign o_valid   = (state == S_SEND);
  assign unused_wdata = ^bus_wdata[31:8];

  sync_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push      (dat_wr),
    .push_data (bus_wdata[7:0]),
    .pop       (pop),
    .flush     (flush),
    .pop_data  (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          load       = 1'b1;
          state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (i_ready) begin
          if (!empty) begin
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      o_data      <= '0;
      ovf         <= 1'b0;
      o_irq_empty <= 1'b1;
      bus_rdata   <= '0;
    end else begin
      state <= state_next;
      // A flush in the same cycle still lets the popped head load here.
      if (load) o_data <= head;
      if (push_drop)    ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      // Heading to IDLE implies the FIFO was empty this cycle; only an
      // accepted push can make it non-empty next cycle.
      o_irq_empty <= (state_next == S_IDLE) & ~push_ok;
      if (rd_en) begin
        if (bus_addr == CTL_OFF) bus_rdata <= ctl_word(count, full, idle, ovf);
        else                     bus_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

  localparam int DEPTH = 16;
  localparam int CNT_W = 5;
  localparam logic [4:0] DAT = 5'h08;
  localparam logic [4:0] CTL = 5'h10;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        bus_valid, bus_we;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic [7:0]  o_data;
  logic        o_valid, i_ready, o_irq_empty;

  uart_tx_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .bus_valid   (bus_valid),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_irq_empty (o_irq_empty)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic bus_idle();
    bus_valid = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus_valid = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    step();
    bus_idle();
  endtask

  task automatic rd(input logic [4:0] a);
    bus_valid = 1'b1; bus_we = 1'b0; bus_addr = a; bus_wdata = '0;
    step();
    bus_idle();
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic        bv;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic        rdy;
    logic        ev;
    logic [7:0]  ed;
    logic        eirq;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl[10];

  // ---------------- behavioural reference model ----------------
  logic [7:0]  mq[$];
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ovf;
  logic        m_irq;
  logic [31:0] m_rdata;

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0; m_data = '0; m_ovf = 1'b0; m_irq = 1'b1; m_rdata = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int   sz;
    bit   full0, idle0, dat, ctlw, fl, clr, drop;
    logic [31:0] ctl;
    sz    = mq.size();
    full0 = (sz == DEPTH);
    idle0 = (sz == 0) && !m_valid;
    ctl   = 32'(sz) + (full0 ? 32'h200 : 32'h0) + (idle0 ? 32'h400 : 32'h0)
          + (m_ovf ? 32'h800 : 32'h0);
    if (bus_valid && !bus_we) m_rdata = (bus_addr == CTL) ? ctl : 32'h0;
    dat  = bus_valid && bus_we && (bus_addr == DAT);
    ctlw = bus_valid && bus_we && (bus_addr == CTL);
    fl   = ctlw && bus_wdata[0];
    clr  = ctlw && bus_wdata[1];
    // The output slot refills whenever it is free or being consumed.
    if (!m_valid || i_ready) begin
      if (sz > 0) begin
        m_data  = mq.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (fl) mq.delete();
    drop = dat && !fl && full0;
    if (dat && !fl && !full0) mq.push_back(bus_wdata[7:0]);
    if (drop)     m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_irq = !m_valid && (mq.size() == 0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, DAT,   32'h41, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, DAT,   32'h42, 1'b1, 1'b1, 8'h41, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, DAT,   32'h43, 1'b1, 1'b1, 8'h42, 1'b0, 32'h0};
    tbl[3] = '{1'b0, 1'b0, 5'h00, 32'h0,  1'b1, 1'b1, 8'h43, 1'b0, 32'h0};
    tbl[4] = '{1'b0, 1'b0, 5'h00, 32'h0,  1'b1, 1'b0, 8'h00, 1'b1, 32'h0};
    tbl[5] = '{1'b1, 1'b0, CTL,   32'h0,  1'b1, 1'b0, 8'h00, 1'b1, 32'h400};
    tbl[6] = '{1'b1, 1'b0, 5'h04, 32'h0,  1'b1, 1'b0, 8'h00, 1'b1, 32'h0};
    tbl[7] = '{1'b1, 1'b1, 5'h04, 32'hFFFF_FFFF, 1'b1, 1'b0, 8'h00, 1'b1, 32'h0};
    tbl[8] = '{1'b1, 1'b0, CTL,   32'h0,  1'b1, 1'b0, 8'h00, 1'b1, 32'h400};
    tbl[9] = '{1'b1, 1'b0, DAT,   32'h0,  1'b1, 1'b0, 8'h00, 1'b1, 32'h0};

    // ---------------- reset state ----------------
    i_rst = 1'b1;
    i_ready = 1'b0;
    bus_idle();
    step();
    step();
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_data", 32'(o_data), 32'h0);
    chk("rst_irq", 32'(o_irq_empty), 32'h1);
    chk("rst_rdata", bus_rdata, 32'h0);
    i_rst = 1'b0;
    step();

    // ---------------- table vectors ----------------
    for (int i = 0; i < 10; i++) begin
      bus_valid = tbl[i].bv; bus_we = tbl[i].we;
      bus_addr = tbl[i].addr; bus_wdata = tbl[i].wd;
      i_ready = tbl[i].rdy;
      step();
      bus_idle();
      chk($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), 32'(o_data), 32'(tbl[i].ed));
      chk($sformatf("tbl%0d_irq", i), 32'(o_irq_empty), 32'(tbl[i].eirq));
      chk($sformatf("tbl%0d_rdata", i), bus_rdata, tbl[i].erd);
    end

    // ---------------- overflow with emitter stalled ----------------
    i_ready = 1'b0;
    for (int k = 1; k <= 16; k++) wr(DAT, 32'(k));
    rd(CTL);
    chk("ovf_cnt15", bus_rdata, 32'h00F);
    chk("ovf_hold_valid", 32'(o_valid), 32'h1);
    chk("ovf_hold_data", 32'(o_data), 32'h01);
    wr(DAT, 32'd17);
    rd(CTL);
    chk("ovf_full16", bus_rdata, 32'h210);
    wr(DAT, 32'd18);
    rd(CTL);
    chk("ovf_dropped", bus_rdata, 32'hA10);
    wr(CTL, 32'h2);
    rd(CTL);
    chk("ovf_cleared", bus_rdata, 32'h210);

    // ---------------- full FIFO: pop and push on the same edge ----------------
    i_ready = 1'b1;
    wr(DAT, 32'd19);
    i_ready = 1'b0;
    rd(CTL);
    chk("fullpop_ctl", bus_rdata, 32'h80F);
    chk("fullpop_data", 32'(o_data), 32'h02);

    // ---------------- flush keeps the in-flight byte ----------------
    wr(CTL, 32'h3);
    rd(CTL);
    chk("flush_ctl", bus_rdata, 32'h000);
    chk("flush_valid", 32'(o_valid), 32'h1);
    chk("flush_data", 32'(o_data), 32'h02);
    chk("flush_irq", 32'(o_irq_empty), 32'h0);
    i_ready = 1'b1;
    step();
    chk("flush_done_valid", 32'(o_valid), 32'h0);
    chk("flush_done_irq", 32'(o_irq_empty), 32'h1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("flush_quiet%0d", k), 32'(o_valid), 32'h0);
    end
    i_ready = 1'b0;

    // ---------------- asynchronous reset mid-SEND ----------------
    wr(DAT, 32'hA0);
    wr(DAT, 32'hA1);
    wr(DAT, 32'hA2);
    wr(DAT, 32'hA3);
    rd(CTL);
    chk("prerst_ctl", bus_rdata, 32'h003);
    chk("prerst_valid", 32'(o_valid), 32'h1);
    #2 i_rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(o_valid), 32'h0);
    chk("async_rst_irq", 32'(o_irq_empty), 32'h1);
    chk("async_rst_data", 32'(o_data), 32'h0);
    chk("async_rst_rdata", bus_rdata, 32'h0);
    step();
    i_rst = 1'b0;
    i_ready = 1'b1;
    rd(CTL);
    chk("postrst_ctl", bus_rdata, 32'h400);
    step();
    chk("postrst_no_replay", 32'(o_valid), 32'h0);

    // ---------------- randomized run against the model ----------------
    i_rst = 1'b1;
    i_ready = 1'b0;
    bus_idle();
    step();
    i_rst = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int r;
      r = int'($urandom_range(0, 99));
      bus_idle();
      if (r < 45) begin
        bus_valid = 1'b1; bus_we = 1'b1; bus_addr = DAT; bus_wdata = $urandom;
      end else if (r < 62) begin
        bus_valid = 1'b1; bus_we = 1'b0; bus_addr = CTL;
      end else if (r < 64) begin
        bus_valid = 1'b1; bus_we = 1'b1; bus_addr = CTL; bus_wdata = $urandom_range(0, 3);
      end else if (r < 67) begin
        bus_valid = 1'b1; bus_we = 1'b1; bus_addr = CTL; bus_wdata = 32'h2;
      end else if (r < 72) begin
        bus_valid = 1'b1; bus_we = ($urandom_range(0, 1) == 1);
        bus_addr = 5'($urandom_range(0, 31)); bus_wdata = $urandom;
      end
      if (((cyc / 200) % 2) == 1) i_ready = ($urandom_range(0, 3) == 0);
      else                        i_ready = ($urandom_range(0, 3) != 0);
      model_step();
      step();
      chk("rnd_valid", 32'(o_valid), 32'(m_valid));
      chk("rnd_data", 32'(o_data), 32'(m_data));
      chk("rnd_irq", 32'(o_irq_empty), 32'(m_irq));
      chk("rnd_rdata", bus_rdata, m_rdata);
    end
    bus_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
